// File: rtl/mine_placer_if.sv
// Request/status bundle between the mine placer and the game controller.
// Controller side drives requests and seeds; placer side returns the map and status.
interface mine_placer_if #(
  parameter int GRID_SIZE = 5
);
  localparam int TOTAL_SQUARES = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W         = $clog2(TOTAL_SQUARES);

  logic                     gen_start;
  logic                     seed_load;
  logic [15:0]              seed_in;
  logic                     safe_en;
  logic [IDX_W-1:0]         safe_idx;
  logic [TOTAL_SQUARES-1:0] mine_map;
  logic [IDX_W:0]           mine_count;
  logic                     busy;
  logic                     done;

  modport master (
    output gen_start, seed_load, seed_in, safe_en, safe_idx,
    input  mine_map, mine_count, busy, done
  );

  modport slave (
    input  gen_start, seed_load, seed_in, safe_en, safe_idx,
    output mine_map, mine_count, busy, done
  );
endinterface

// File: rtl/mine_placer.sv
// Random mine-map generator: free-running 16-bit LFSR feeding a rejection-sampling
// placement FSM; the finished map is held with done=1 until the next request.
module mine_placer #(
  parameter int          GRID_SIZE     = 5,
  parameter int          NUM_MINES     = 6,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          TOTAL_SQUARES = GRID_SIZE * GRID_SIZE,
  parameter int          IDX_W         = $clog2(TOTAL_SQUARES)
) (
  input  logic          clk,
  input  logic          rst,
  mine_placer_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PICK  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IDX_W:0] TOT_L = (IDX_W+1)'(TOTAL_SQUARES);
  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_MINES);
  localparam logic [TOTAL_SQUARES-1:0] ONE_L = {{(TOTAL_SQUARES-1){1'b0}}, 1'b1};

  logic [2:0]               r_state;
  logic [15:0]              r_lfsr;
  logic [TOTAL_SQUARES-1:0] r_map;
  logic [IDX_W:0]           r_count;
  logic [IDX_W-1:0]         r_cand;
  logic                     r_safe_en;
  logic [IDX_W-1:0]         r_safe_idx;
  logic                     r_done;

  logic                     w_fb;
  logic [15:0]              w_seed;
  logic                     w_in_range;
  logic                     w_reject;
  logic [IDX_W:0]           w_count_inc;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // A zero seed would lock the LFSR up, so it falls back to the default seed.
  assign w_seed      = (bus.seed_in == 16'd0) ? SEED : bus.seed_in;
  assign w_in_range  = ({1'b0, r_cand} < TOT_L);
  assign w_reject    = !w_in_range || r_map[r_cand] ||
                       (r_safe_en && (r_cand == r_safe_idx));
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_map      <= '0;
      r_count    <= '0;
      r_cand     <= '0;
      r_safe_en  <= 1'b0;
      r_safe_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_lfsr <= bus.seed_load ? w_seed : {r_lfsr[14:0], w_fb};
      case (r_state)
        S_IDLE: if (bus.gen_start) r_state <= S_CLEAR;
        S_CLEAR: begin
          r_map      <= '0;
          r_count    <= '0;
          r_safe_en  <= bus.safe_en;
          r_safe_idx <= bus.safe_idx;
          r_state    <= S_PICK;
        end
        S_PICK: begin
          r_cand  <= r_lfsr[IDX_W-1:0];
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (!w_reject) begin
            r_map   <= r_map | (ONE_L << r_cand);
            r_count <= w_count_inc;
            r_state <= (w_count_inc == NUM_L) ? S_DONE : S_PICK;
          end else begin
            r_state <= S_PICK;
          end
        end
        S_DONE: if (bus.gen_start) r_state <= S_CLEAR;
        default: r_state <= S_IDLE;
      endcase
      // done asserts one cycle after DONE is entered and drops with the edge that restarts.
      r_done <= (r_state == S_DONE) && !bus.gen_start;
    end
  end

  assign bus.mine_map   = r_map;
  assign bus.mine_count = r_count;
  assign bus.busy       = (r_state == S_CLEAR) || (r_state == S_PICK) || (r_state == S_CHECK);
  assign bus.done       = r_done;

endmodule

// File: tb/tb_mine_placer.sv
// Randomized self-checking bench for mine_placer against a behavioural placement model.
module tb_mine_placer;
  localparam int          NM   = 6;
  localparam int          TS   = 25;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mine_placer_if #(.GRID_SIZE(5)) bus ();
  mine_placer u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] m_lfsr  = SEED;
  logic [24:0] basic_map;

  function automatic logic [15:0] lf(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Candidates are every other LFSR value starting one shift after the request edge.
  task automatic predict(input logic [15:0] v0, input logic se, input logic [4:0] si,
                         output logic [24:0] map, output int att);
    logic [15:0] l;
    int n, c;
    l = lf(v0); map = '0; att = 0; n = 0;
    while (n < NM && att < 10000) begin
      c = int'(l[4:0]);
      att++;
      if (c < TS && !map[c] && !(se && c == int'(si))) begin
        map[c] = 1'b1;
        n++;
      end
      l = lf(lf(l));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) m_lfsr = SEED;
    else if (bus.seed_load) m_lfsr = (bus.seed_in == 16'd0) ? SEED : bus.seed_in;
    else m_lfsr = lf(m_lfsr);
    #1;
  endtask

  task automatic gen(input string nm, input logic sload, input logic [15:0] sin,
                     input logic se, input logic [4:0] si, input int poke,
                     output logic [24:0] map_o);
    logic [15:0] v0;
    logic [24:0] exp_map;
    int att, exp_cyc, cyc;
    bus.gen_start = 1'b1; bus.seed_load = sload; bus.seed_in = sin;
    bus.safe_en = se; bus.safe_idx = si;
    step();
    v0 = m_lfsr;
    bus.gen_start = 1'b0; bus.seed_load = 1'b0;
    predict(v0, se, si, exp_map, att);
    exp_cyc = 2 + 2 * att;
    n_total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL %s start: busy=%b done=%b required busy=1 done=0", nm, bus.busy, bus.done);
    else n_pass++;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4000) begin
      if (cyc + 1 == poke) bus.gen_start = 1'b1;
      step();
      bus.gen_start = 1'b0;
      cyc++;
    end
    n_total++;
    if (cyc != exp_cyc) $display("FAIL %s latency: got %0d cycles required %0d", nm, cyc, exp_cyc);
    else n_pass++;
    n_total++;
    if (bus.mine_map !== exp_map || bus.mine_count !== 6'(NM) || bus.busy !== 1'b0)
      $display("FAIL %s map: map=%h count=%0d busy=%b required map=%h count=%0d busy=0",
               nm, bus.mine_map, bus.mine_count, bus.busy, exp_map, NM);
    else n_pass++;
    map_o = bus.mine_map;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    m_lfsr = SEED;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.gen_start = 0; bus.seed_load = 0; bus.seed_in = 0; bus.safe_en = 0; bus.safe_idx = 0;
    do_reset();
    repeat (5) step();
    n_total++;
    if (bus.mine_map !== '0 || bus.mine_count !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_idle: map=%h count=%0d busy=%b done=%b required all zero",
               bus.mine_map, bus.mine_count, bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [24:0] m;
    bit stable;
    do_reset();
    repeat (3) step();
    gen("basic", 1'b0, 16'd0, 1'b0, 5'd0, 0, m);
    basic_map = m;
    n_total++;
    if ($countones(bus.mine_map) != NM)
      $display("FAIL basic_popcount: got %0d required %0d", $countones(bus.mine_map), NM);
    else n_pass++;
    stable = 1'b1;
    repeat (50) begin
      step();
      if (bus.mine_map !== m || bus.done !== 1'b1 || bus.mine_count !== 6'(NM)) stable = 1'b0;
    end
    n_total++;
    if (!stable) $display("FAIL basic_hold: map=%h done=%b required map=%h done=1", bus.mine_map, bus.done, m);
    else n_pass++;
  endtask

  task automatic test_safe(input logic [4:0] si, input int iters);
    logic [24:0] m;
    int bad = 0;
    for (int i = 0; i < iters; i++) begin
      gen("safe", 1'b1, 16'($urandom), 1'b1, si, 0, m);
      if ((si < 5'd25 && m[si]) || $countones(m) != NM) bad++;
      step();
    end
    n_total++;
    if (bad != 0) $display("FAIL safe_excl idx=%0d: %0d bad maps required 0", si, bad);
    else n_pass++;
  endtask

  task automatic test_seed();
    logic [24:0] a, b, c, d;
    bus.seed_load = 1'b1; bus.seed_in = 16'd0; step(); bus.seed_load = 1'b0;
    repeat (3) step();
    gen("seed_zero", 1'b0, 16'd0, 1'b0, 5'd0, 0, a);
    step();
    bus.seed_load = 1'b1; bus.seed_in = SEED; step(); bus.seed_load = 1'b0;
    repeat (3) step();
    gen("seed_ace1", 1'b0, 16'd0, 1'b0, 5'd0, 0, b);
    n_total++;
    if (a !== b) $display("FAIL seed_zero_vs_default: got %h required %h", a, b);
    else n_pass++;
    gen("seed_rep1", 1'b1, 16'h1234, 1'b0, 5'd0, 0, c);
    step(); step();
    gen("seed_rep2", 1'b1, 16'h1234, 1'b0, 5'd0, 0, d);
    n_total++;
    if (c !== d) $display("FAIL seed_reuse: got %h required %h", d, c);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [24:0] m;
    bit held;
    gen("ignore_busy", 1'b1, 16'h5A5A, 1'b0, 5'd0, 3, m);
    held = 1'b1;
    repeat (5) begin
      step();
      if (bus.done !== 1'b1) held = 1'b0;
    end
    n_total++;
    if (!held) $display("FAIL single_done_rise: done=%b required 1", bus.done);
    else n_pass++;
    gen("regen_from_done", 1'b0, 16'd0, 1'b1, 5'(($urandom % 25)), 0, m);
  endtask

  task automatic test_reset_mid();
    logic [24:0] m;
    do_reset();
    repeat (3) step();
    bus.gen_start = 1'b1; step(); bus.gen_start = 1'b0;
    repeat (6) step();
    #1 rst = 1'b0;
    m_lfsr = SEED;
    #1;
    n_total++;
    if (bus.mine_map !== '0 || bus.mine_count !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_mid: map=%h count=%0d busy=%b done=%b required all zero",
               bus.mine_map, bus.mine_count, bus.busy, bus.done);
    else n_pass++;
    step(); step();
    rst = 1'b1;
    repeat (3) step();
    gen("post_reset", 1'b0, 16'd0, 1'b0, 5'd0, 0, m);
    n_total++;
    if (m !== basic_map) $display("FAIL reset_repro: got %h required %h", m, basic_map);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_safe(5'd12, 200);
    test_safe(5'd31, 200);
    test_seed();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
